retire_lockstep_checker: RTL and testbench

Synthesizable lockstep checker for the CPU co-simulation harness. It takes two instruction-retire streams, one from the CPU under test and one from the golden CPU, and buffers each in its own FIFO. Retire events are paired in program order; PC, register-write address and write data are compared. The first divergence, overflow or stall is latched with full context, so the bench or an FPGA debug register can report it.

---
 rtl/lockstep_pkg.sv | 26 ++
 rtl/retire_fifo.sv | 51 +++++
 rtl/retire_lockstep_checker.sv | 172 +++++++++++++++++
 tb/tb_retire_lockstep_checker.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/lockstep_pkg.sv
// Shared types and constants for the retire lockstep checker.
// CMP_MASK_EN adds a per-entry wdata compare mask to the retire entry.
package lockstep_pkg;

    // Entries are stored at this width; narrower DATA_W values are zero-extended.
    localparam int LS_DATA_W = 32;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_MISMATCH = 2'd1;
    localparam logic [1:0] ERR_OVERFLOW = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

    typedef struct packed {
        logic [LS_DATA_W-1:0] pc;
        logic [4:0]           waddr;
        logic [LS_DATA_W-1:0] wdata;
`ifdef CMP_MASK_EN
        logic [LS_DATA_W-1:0] mask;
`endif
    } retire_entry_t;

    function automatic int addr_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/retire_fifo.sv
// Retire-event FIFO: registered write, combinational head, no bypass.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module retire_fifo
    import lockstep_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int ADDR_W = addr_w(DEPTH);
    localparam logic [ADDR_W:0] PTR_ONE = 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_W:0]  r_wptr;
    logic [ADDR_W:0]  r_rptr;

    // Storage is not reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push && !clr)
            r_mem[r_wptr[ADDR_W-1:0]] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else if (clr) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (push) r_wptr <= r_wptr + PTR_ONE;
            if (pop)  r_rptr <= r_rptr + PTR_ONE;
        end
    end

    assign empty = (r_wptr == r_rptr);
    assign full  = (r_wptr[ADDR_W] != r_rptr[ADDR_W]) &&
                   (r_wptr[ADDR_W-1:0] == r_rptr[ADDR_W-1:0]);
    assign head  = r_mem[r_rptr[ADDR_W-1:0]];

endmodule

// File: rtl/retire_lockstep_checker.sv
// Pairs DUT and golden retire streams in order and latches the first
// mismatch, overflow or timeout. CMP_MASK_EN enables the ref_mask port.
module retire_lockstep_checker
    import lockstep_pkg::*;
#(
    parameter int DATA_W  = LS_DATA_W,
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 1024,
    parameter int SKIP_X0 = 1
) (
    input  logic              sys_clk,
    input  logic              sys_reset_n,
    input  logic              clr,
    input  logic              dut_valid,
    input  logic [DATA_W-1:0] dut_pc,
    input  logic [4:0]        dut_waddr,
    input  logic [DATA_W-1:0] dut_wdata,
    input  logic              ref_valid,
    input  logic [DATA_W-1:0] ref_pc,
    input  logic [4:0]        ref_waddr,
    input  logic [DATA_W-1:0] ref_wdata,
`ifdef CMP_MASK_EN
    input  logic [DATA_W-1:0] ref_mask,
`endif
    output logic              err,
    output logic [1:0]        err_code,
    output logic [DATA_W-1:0] err_dut_pc,
    output logic [DATA_W-1:0] err_ref_pc,
    output logic [DATA_W-1:0] err_dut_wdata,
    output logic [DATA_W-1:0] err_ref_wdata,
    output logic [31:0]       cmp_count
);

    localparam int EW = $bits(retire_entry_t);

    logic              r_err;
    logic [1:0]        r_err_code;
    logic [DATA_W-1:0] r_err_dut_pc;
    logic [DATA_W-1:0] r_err_ref_pc;
    logic [DATA_W-1:0] r_err_dut_wdata;
    logic [DATA_W-1:0] r_err_ref_wdata;
    logic [31:0]       r_cmp_count;
    logic [31:0]       r_tmo;

    retire_entry_t w_dut_in, w_ref_in, w_dut_head, w_ref_head;
    logic          w_dut_full, w_dut_empty, w_ref_full, w_ref_empty;
    logic          w_dut_push, w_ref_push, w_dut_wr, w_ref_wr;
    logic          w_pop, w_match, w_mismatch, w_ovf, w_one, w_tmo, w_any_err;
    logic [1:0]    w_err_code;
    logic [LS_DATA_W-1:0] w_mask;
    logic [31:0]   w_tmo_next;

    always_comb begin
        w_dut_in       = '0;
        w_dut_in.pc    = LS_DATA_W'(dut_pc);
        w_dut_in.waddr = dut_waddr;
        w_dut_in.wdata = LS_DATA_W'(dut_wdata);
        w_ref_in       = '0;
        w_ref_in.pc    = LS_DATA_W'(ref_pc);
        w_ref_in.waddr = ref_waddr;
        w_ref_in.wdata = LS_DATA_W'(ref_wdata);
`ifdef CMP_MASK_EN
        w_ref_in.mask  = LS_DATA_W'(ref_mask);
`endif
    end

    assign w_dut_push = dut_valid && !r_err && (SKIP_X0 == 0 || dut_waddr != 5'd0);
    assign w_ref_push = ref_valid && !r_err && (SKIP_X0 == 0 || ref_waddr != 5'd0);
    assign w_pop      = !w_dut_empty && !w_ref_empty && !r_err;

    // A push into a full FIFO without a pop is the overflow case; drop it.
    assign w_dut_wr = w_dut_push && (!w_dut_full || w_pop);
    assign w_ref_wr = w_ref_push && (!w_ref_full || w_pop);

    retire_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_dut_fifo (
        .clk   (sys_clk),
        .rst_n (sys_reset_n),
        .clr   (clr),
        .push  (w_dut_wr),
        .pop   (w_pop),
        .din   (w_dut_in),
        .head  (w_dut_head),
        .full  (w_dut_full),
        .empty (w_dut_empty)
    );

    retire_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_ref_fifo (
        .clk   (sys_clk),
        .rst_n (sys_reset_n),
        .clr   (clr),
        .push  (w_ref_wr),
        .pop   (w_pop),
        .din   (w_ref_in),
        .head  (w_ref_head),
        .full  (w_ref_full),
        .empty (w_ref_empty)
    );

`ifdef CMP_MASK_EN
    assign w_mask = w_ref_head.mask;
`else
    assign w_mask = '1;
`endif

    assign w_match = (w_dut_head.pc == w_ref_head.pc) &&
                     (w_dut_head.waddr == w_ref_head.waddr) &&
                     ((w_dut_head.wdata & w_mask) == (w_ref_head.wdata & w_mask));

    assign w_mismatch = w_pop && !w_match;
    assign w_ovf      = !r_err && ((w_dut_push && w_dut_full && !w_pop) ||
                                   (w_ref_push && w_ref_full && !w_pop));

    // Backlog timer runs only while exactly one side holds entries.
    assign w_one      = w_dut_empty ^ w_ref_empty;
    assign w_tmo      = !r_err && (TIMEOUT != 0) && w_one && !w_pop &&
                        (r_tmo == 32'(TIMEOUT - 1));
    assign w_tmo_next = (w_pop || !w_one) ? 32'd0 : r_tmo + 32'd1;

    assign w_any_err  = w_mismatch || w_ovf || w_tmo;

    always_comb begin
        w_err_code = ERR_TIMEOUT;
        if (w_mismatch)
            w_err_code = ERR_MISMATCH;
        else if (w_ovf)
            w_err_code = ERR_OVERFLOW;
    end

    always_ff @(posedge sys_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            r_err           <= 1'b0;
            r_err_code      <= ERR_NONE;
            r_err_dut_pc    <= '0;
            r_err_ref_pc    <= '0;
            r_err_dut_wdata <= '0;
            r_err_ref_wdata <= '0;
            r_cmp_count     <= '0;
            r_tmo           <= '0;
        end else if (clr) begin
            r_err           <= 1'b0;
            r_err_code      <= ERR_NONE;
            r_err_dut_pc    <= '0;
            r_err_ref_pc    <= '0;
            r_err_dut_wdata <= '0;
            r_err_ref_wdata <= '0;
            r_cmp_count     <= '0;
            r_tmo           <= '0;
        end else if (!r_err) begin
            r_tmo <= w_tmo_next;
            if (w_pop && w_match && r_cmp_count != 32'hFFFF_FFFF)
                r_cmp_count <= r_cmp_count + 32'd1;
            // Every error class captures a side's head, or zero if that side is empty.
            if (w_any_err) begin
                r_err           <= 1'b1;
                r_err_code      <= w_err_code;
                r_err_dut_pc    <= w_dut_empty ? '0 : DATA_W'(w_dut_head.pc);
                r_err_dut_wdata <= w_dut_empty ? '0 : DATA_W'(w_dut_head.wdata);
                r_err_ref_pc    <= w_ref_empty ? '0 : DATA_W'(w_ref_head.pc);
                r_err_ref_wdata <= w_ref_empty ? '0 : DATA_W'(w_ref_head.wdata);
            end
        end
    end

    assign err           = r_err;
    assign err_code      = r_err_code;
    assign err_dut_pc    = r_err_dut_pc;
    assign err_ref_pc    = r_err_ref_pc;
    assign err_dut_wdata = r_err_dut_wdata;
    assign err_ref_wdata = r_err_ref_wdata;
    assign cmp_count     = r_cmp_count;

endmodule

// File: tb/tb_retire_lockstep_checker.sv
// Directed bench for retire_lockstep_checker (DEPTH=16, TIMEOUT=100, SKIP_X0=1).
// The masked-compare scenario is built only when CMP_MASK_EN is defined.
module tb_retire_lockstep_checker;

    logic        sys_clk;
    logic        sys_reset_n;
    logic        clr;
    logic        dut_valid;
    logic [31:0] dut_pc;
    logic [4:0]  dut_waddr;
    logic [31:0] dut_wdata;
    logic        ref_valid;
    logic [31:0] ref_pc;
    logic [4:0]  ref_waddr;
    logic [31:0] ref_wdata;
`ifdef CMP_MASK_EN
    logic [31:0] ref_mask;
`endif
    logic        err;
    logic [1:0]  err_code;
    logic [31:0] err_dut_pc, err_ref_pc, err_dut_wdata, err_ref_wdata;
    logic [31:0] cmp_count;

    int total = 0;
    int bad   = 0;

    retire_lockstep_checker #(
        .DATA_W(32), .DEPTH(16), .TIMEOUT(100), .SKIP_X0(1)
    ) dut (
        .sys_clk       (sys_clk),
        .sys_reset_n   (sys_reset_n),
        .clr           (clr),
        .dut_valid     (dut_valid),
        .dut_pc        (dut_pc),
        .dut_waddr     (dut_waddr),
        .dut_wdata     (dut_wdata),
        .ref_valid     (ref_valid),
        .ref_pc        (ref_pc),
        .ref_waddr     (ref_waddr),
        .ref_wdata     (ref_wdata),
`ifdef CMP_MASK_EN
        .ref_mask      (ref_mask),
`endif
        .err           (err),
        .err_code      (err_code),
        .err_dut_pc    (err_dut_pc),
        .err_ref_pc    (err_ref_pc),
        .err_dut_wdata (err_dut_wdata),
        .err_ref_wdata (err_ref_wdata),
        .cmp_count     (cmp_count)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic drive(input logic dv, input logic [31:0] dpc, input logic [4:0] dwa,
                         input logic [31:0] dwd, input logic rv, input logic [31:0] rpc,
                         input logic [4:0] rwa, input logic [31:0] rwd);
        dut_valid = dv; dut_pc = dpc; dut_waddr = dwa; dut_wdata = dwd;
        ref_valid = rv; ref_pc = rpc; ref_waddr = rwa; ref_wdata = rwd;
        tick();
        dut_valid = 1'b0;
        ref_valid = 1'b0;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    task automatic test_reset();
        sys_reset_n = 1'b0;
        idle(2);
        sys_reset_n = 1'b1;
        idle(1);
        total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%0b want=0", err); end
        total++; if (err_code !== 2'd0) begin bad++; $display("FAIL reset_code got=%0d want=0", err_code); end
        total++; if (cmp_count !== 32'd0) begin bad++; $display("FAIL reset_cmp got=%0d want=0", cmp_count); end
        total++; if (err_dut_pc !== 32'd0 || err_ref_wdata !== 32'd0)
            begin bad++; $display("FAIL reset_ctx got=%h/%h want=0/0", err_dut_pc, err_ref_wdata); end
    endtask

    task automatic test_lockstep();
        do_clr();
        for (int i = 0; i < 8; i++)
            drive(1'b1, 32'h100 + 32'(i * 4), 5'(i + 1), 32'(i * 17),
                  1'b1, 32'h100 + 32'(i * 4), 5'(i + 1), 32'(i * 17));
        idle(2);
        total++; if (cmp_count !== 32'd8) begin bad++; $display("FAIL lockstep_cmp got=%0d want=8", cmp_count); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL lockstep_err got=%0b want=0", err); end
    endtask

    task automatic test_skew();
        do_clr();
        for (int i = 0; i < 5; i++)
            drive(1'b0, 32'h0, 5'd0, 32'h0, 1'b1, 32'h200 + 32'(i * 4), 5'd7, 32'hA0 + 32'(i));
        total++; if (cmp_count !== 32'd0) begin bad++; $display("FAIL skew_early_cmp got=%0d want=0", cmp_count); end
        for (int i = 0; i < 5; i++)
            drive(1'b1, 32'h200 + 32'(i * 4), 5'd7, 32'hA0 + 32'(i), 1'b0, 32'h0, 5'd0, 32'h0);
        idle(2);
        total++; if (cmp_count !== 32'd5) begin bad++; $display("FAIL skew_cmp got=%0d want=5", cmp_count); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL skew_err got=%0b want=0", err); end
    endtask

    task automatic test_mismatch();
        do_clr();
        drive(1'b1, 32'h38, 5'd2, 32'h11, 1'b1, 32'h38, 5'd2, 32'h11);
        drive(1'b1, 32'h3C, 5'd3, 32'h22, 1'b1, 32'h3C, 5'd3, 32'h22);
        drive(1'b1, 32'h40, 5'd4, 32'h1234, 1'b1, 32'h40, 5'd4, 32'h1235);
        idle(2);
        total++; if (err !== 1'b1 || err_code !== 2'd1)
            begin bad++; $display("FAIL mismatch_code got=%0b/%0d want=1/1", err, err_code); end
        total++; if (err_dut_pc !== 32'h40 || err_ref_pc !== 32'h40)
            begin bad++; $display("FAIL mismatch_pc got=%h/%h want=40/40", err_dut_pc, err_ref_pc); end
        total++; if (err_dut_wdata !== 32'h1234 || err_ref_wdata !== 32'h1235)
            begin bad++; $display("FAIL mismatch_wdata got=%h/%h want=1234/1235", err_dut_wdata, err_ref_wdata); end
        total++; if (cmp_count !== 32'd2) begin bad++; $display("FAIL mismatch_cmp got=%0d want=2", cmp_count); end
        for (int i = 0; i < 3; i++)
            drive(1'b1, 32'h80, 5'd5, 32'h9, 1'b1, 32'h84, 5'd5, 32'h9);
        idle(2);
        total++; if (cmp_count !== 32'd2 || err_dut_pc !== 32'h40 || err_code !== 2'd1)
            begin bad++; $display("FAIL mismatch_frozen got=%0d/%h/%0d want=2/40/1", cmp_count, err_dut_pc, err_code); end
    endtask

    task automatic test_clr();
        do_clr();
        total++; if (err !== 1'b0 || err_code !== 2'd0 || cmp_count !== 32'd0 || err_ref_pc !== 32'd0)
            begin bad++; $display("FAIL clr_state got=%0b/%0d/%0d/%h want=0/0/0/0", err, err_code, cmp_count, err_ref_pc); end
    endtask

    task automatic test_x0_filter();
        do_clr();
        drive(1'b1, 32'h300, 5'd0, 32'hDEAD, 1'b0, 32'h0, 5'd0, 32'h0);
        for (int i = 0; i < 3; i++)
            drive(1'b1, 32'h304 + 32'(i * 4), 5'd9, 32'h50 + 32'(i),
                  1'b1, 32'h304 + 32'(i * 4), 5'd9, 32'h50 + 32'(i));
        idle(2);
        total++; if (err !== 1'b0) begin bad++; $display("FAIL x0_err got=%0b want=0", err); end
        total++; if (cmp_count !== 32'd3) begin bad++; $display("FAIL x0_cmp got=%0d want=3", cmp_count); end
    endtask

    task automatic test_overflow();
        do_clr();
        for (int i = 0; i < 16; i++)
            drive(1'b0, 32'h0, 5'd0, 32'h0, 1'b1, 32'h1000 + 32'(i * 4), 5'd1, 32'hC00 + 32'(i));
        total++; if (err !== 1'b0) begin bad++; $display("FAIL ovf_full_no_err got=%0b want=0", err); end
        drive(1'b0, 32'h0, 5'd0, 32'h0, 1'b1, 32'h1040, 5'd1, 32'hC10);
        total++; if (err !== 1'b1 || err_code !== 2'd2)
            begin bad++; $display("FAIL ovf_code got=%0b/%0d want=1/2", err, err_code); end
        total++; if (err_ref_pc !== 32'h1000 || err_ref_wdata !== 32'hC00)
            begin bad++; $display("FAIL ovf_ref_ctx got=%h/%h want=1000/c00", err_ref_pc, err_ref_wdata); end
        total++; if (err_dut_pc !== 32'd0 || err_dut_wdata !== 32'd0)
            begin bad++; $display("FAIL ovf_dut_ctx got=%h/%h want=0/0", err_dut_pc, err_dut_wdata); end
    endtask

    task automatic test_timeout();
        do_clr();
        drive(1'b1, 32'h200, 5'd3, 32'hABCD, 1'b0, 32'h0, 5'd0, 32'h0);
        idle(99);
        total++; if (err !== 1'b0) begin bad++; $display("FAIL tmo_early got=%0b want=0", err); end
        idle(1);
        total++; if (err !== 1'b1 || err_code !== 2'd3)
            begin bad++; $display("FAIL tmo_code got=%0b/%0d want=1/3", err, err_code); end
        total++; if (err_dut_pc !== 32'h200 || err_dut_wdata !== 32'hABCD)
            begin bad++; $display("FAIL tmo_dut_ctx got=%h/%h want=200/abcd", err_dut_pc, err_dut_wdata); end
        total++; if (err_ref_pc !== 32'd0 || err_ref_wdata !== 32'd0)
            begin bad++; $display("FAIL tmo_ref_ctx got=%h/%h want=0/0", err_ref_pc, err_ref_wdata); end
    endtask

    task automatic test_async_reset();
        #2;
        sys_reset_n = 1'b0;
        #1;
        total++; if (err !== 1'b0 || err_code !== 2'd0 || err_dut_pc !== 32'd0)
            begin bad++; $display("FAIL areset got=%0b/%0d/%h want=0/0/0", err, err_code, err_dut_pc); end
        #3;
        sys_reset_n = 1'b1;
        idle(1);
        drive(1'b1, 32'h500, 5'd6, 32'h77, 1'b1, 32'h500, 5'd6, 32'h77);
        idle(2);
        total++; if (cmp_count !== 32'd1 || err !== 1'b0)
            begin bad++; $display("FAIL areset_resume got=%0d/%0b want=1/0", cmp_count, err); end
    endtask

`ifdef CMP_MASK_EN
    task automatic test_mask();
        do_clr();
        ref_mask = 32'hFFFF_0000;
        drive(1'b1, 32'h600, 5'd8, 32'h1234_0001, 1'b1, 32'h600, 5'd8, 32'h1234_0002);
        idle(2);
        ref_mask = 32'hFFFF_FFFF;
        total++; if (cmp_count !== 32'd1 || err !== 1'b0)
            begin bad++; $display("FAIL mask_cmp got=%0d/%0b want=1/0", cmp_count, err); end
    endtask
`endif

    initial begin
        clr = 1'b0;
        dut_valid = 1'b0; dut_pc = '0; dut_waddr = '0; dut_wdata = '0;
        ref_valid = 1'b0; ref_pc = '0; ref_waddr = '0; ref_wdata = '0;
`ifdef CMP_MASK_EN
        ref_mask = 32'hFFFF_FFFF;
`endif
        test_reset();
        test_lockstep();
        test_skew();
        test_mismatch();
        test_clr();
        test_x0_filter();
        test_overflow();
        test_timeout();
        test_async_reset();
`ifdef CMP_MASK_EN
        test_mask();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
